// File: rtl/clkbuf_branch_sequencer.sv
// Round-robin sequencer that walks clock-buffer branch enables toward REQ one bit at a time with a GAP-cycle spacing.
// Optional macro CLKBUF_SEQ_FORCE_EN adds a FORCE input that loads EN = REQ in one edge.
module clkbuf_branch_sequencer #(
  parameter int NB    = 4,
  parameter int GAP_W = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [NB-1:0]    REQ,
  input  logic [GAP_W-1:0] GAP,
`ifdef CLKBUF_SEQ_FORCE_EN
  input  logic             FORCE,
`endif
  output logic [NB-1:0]    EN,
  output logic [NB-1:0]    TOG,
  output logic             BUSY,
  output logic             STABLE
);

  localparam int PTR_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [GAP_W-1:0] cnt;
  logic [NB-1:0]    en_p0;
  logic [NB-1:0]    tog_p0;
  logic             stable_p0;

  logic [NB-1:0]    mis;
  logic [PTR_W-1:0] sel;
  logic             sel_vld;
  logic [NB-1:0]    sel_oh;
  logic             force_now;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NB) s = s - NB;
    return PTR_W'(s);
  endfunction

  function automatic logic [GAP_W-1:0] dec_sat(input logic [GAP_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

`ifdef CLKBUF_SEQ_FORCE_EN
  assign force_now = FORCE;
`else
  assign force_now = 1'b0;
`endif

  assign mis = REQ ^ en_p0;

  // First pending branch at or after ptr, wrapping through NB-1 back to 0.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (!sel_vld && mis[wrap_add(ptr, k)]) begin
        sel     = wrap_add(ptr, k);
        sel_vld = 1'b1;
      end
    end
  end

  assign sel_oh = {{(NB-1){1'b0}}, 1'b1} << sel;

  // Stage p0: state, pointer, spacing counter and all registered outputs.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      en_p0     <= '0;
      tog_p0    <= '0;
      stable_p0 <= 1'b0;
    end else begin
      stable_p0 <= (state == IDLE) && (mis == '0);
      tog_p0    <= '0;
      if (force_now) begin
        en_p0  <= REQ;
        tog_p0 <= mis;
        cnt    <= '0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (sel_vld) begin
              en_p0  <= en_p0 ^ sel_oh;
              tog_p0 <= sel_oh;
              ptr    <= wrap_add(sel, 1);
              cnt    <= GAP;
              state  <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt != '0) cnt <= dec_sat(cnt);
            else           state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign EN     = en_p0;
  assign TOG    = tog_p0;
  assign STABLE = stable_p0;
  assign BUSY   = (state == SETTLE) || (mis != '0);

endmodule

// File: tb/tb_clkbuf_branch_sequencer.sv
// Self-checking bench for clkbuf_branch_sequencer: vector table, corner sequences and randomized model comparison.
module tb_clkbuf_branch_sequencer;
  localparam int NB    = 4;
  localparam int GAP_W = 4;

  logic             CLK = 1'b0;
  logic             RN  = 1'b0;
  logic [NB-1:0]    REQ = '0;
  logic [GAP_W-1:0] GAP = '0;
  logic             force_s = 1'b0;
  logic [NB-1:0]    EN, TOG;
  logic             BUSY, STABLE;

  int checks   = 0;
  int failures = 0;

  // Reference: after a toggle with gap g, the next g+1 edges are blocked.
  logic [NB-1:0] m_en, m_tog;
  logic          m_stable;
  int            m_hold, m_ptr;

  clkbuf_branch_sequencer #(.NB(NB), .GAP_W(GAP_W)) dut (
    .CLK(CLK), .RN(RN), .REQ(REQ), .GAP(GAP),
`ifdef CLKBUF_SEQ_FORCE_EN
    .FORCE(force_s),
`endif
    .EN(EN), .TOG(TOG), .BUSY(BUSY), .STABLE(STABLE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NB-1:0]    req;
    logic [GAP_W-1:0] gap;
    int               edges;
    logic [NB-1:0]    en;
    logic [NB-1:0]    tog;
    logic             busy;
    logic             stable;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_tog = '0; m_stable = 1'b0; m_hold = 0; m_ptr = 0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] mis;
    mis      = REQ ^ m_en;
    m_stable = (m_hold == 0) && (mis == '0);
    m_tog    = '0;
    if (force_s) begin
      m_tog  = mis;
      m_en   = REQ;
      m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (mis != '0) begin
      for (int k = 0; k < NB; k++) begin
        int b;
        b = (m_ptr + k) % NB;
        if (mis[b]) begin
          m_tog[b] = 1'b1;
          m_en[b]  = ~m_en[b];
          m_ptr    = (b + 1) % NB;
          m_hold   = int'(GAP) + 1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RN = 1'b0;
    model_reset();
    #2;
    RN = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'd3, 1, 4'b0001, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{4'b1111, 4'd3, 4, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[2]  = '{4'b1111, 4'd3, 1, 4'b0011, 4'b0010, 1'b1, 1'b0};
    tbl[3]  = '{4'b1111, 4'd3, 5, 4'b0111, 4'b0100, 1'b1, 1'b0};
    tbl[4]  = '{4'b1111, 4'd3, 5, 4'b1111, 4'b1000, 1'b1, 1'b0};
    tbl[5]  = '{4'b1111, 4'd3, 3, 4'b1111, 4'b0000, 1'b1, 1'b0};
    tbl[6]  = '{4'b1111, 4'd3, 1, 4'b1111, 4'b0000, 1'b0, 1'b0};
    tbl[7]  = '{4'b1111, 4'd3, 1, 4'b1111, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{4'b0000, 4'd0, 1, 4'b1110, 4'b0001, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 4'd0, 1, 4'b1110, 4'b0000, 1'b1, 1'b0};
    tbl[10] = '{4'b0000, 4'd0, 1, 4'b1100, 4'b0010, 1'b1, 1'b0};
    tbl[11] = '{4'b0000, 4'd0, 2, 4'b1000, 4'b0100, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'd0, 2, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[13] = '{4'b0000, 4'd0, 1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{4'b0000, 4'd0, 1, 4'b0000, 4'b0000, 1'b0, 1'b1};

    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_en", 32'(EN), 32'h0);
    chk("rst_tog", 32'(TOG), 32'h0);
    chk("rst_stable", 32'(STABLE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);

    // Power-up walk then power-down walk.
    RN = 1'b1;
    foreach (tbl[i]) begin
      REQ = tbl[i].req;
      GAP = tbl[i].gap;
      repeat (tbl[i].edges) tick();
      chk($sformatf("vec%0d_en", i), 32'(EN), 32'(tbl[i].en));
      chk($sformatf("vec%0d_tog", i), 32'(TOG), 32'(tbl[i].tog));
      chk($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_stable", i), 32'(STABLE), 32'(tbl[i].stable));
    end

    // Round-robin: park ptr at 2 with EN=0000, then request 0101.
    do_reset();
    REQ = 4'b0011; GAP = 4'd0;
    repeat (4) tick();
    REQ = 4'b0000;
    repeat (5) tick();
    chk("rr_park_en", 32'(EN), 32'h0);
    chk("rr_park_busy", 32'(BUSY), 32'h0);
    REQ = 4'b0101; GAP = 4'd1;
    tick();
    chk("rr_first_tog", 32'(TOG), 32'b0100);
    repeat (2) begin
      tick();
      chk("rr_gap_tog", 32'(TOG), 32'h0);
    end
    tick();
    chk("rr_second_tog", 32'(TOG), 32'b0001);
    chk("rr_second_en", 32'(EN), 32'b0101);
    repeat (2) tick();
    REQ = 4'b0000;
    tick();
    chk("rr_ptr1_tog", 32'(TOG), 32'b0100);

    // REQ glitch on bit3 inside the settle window.
    do_reset();
    REQ = 4'b0001; GAP = 4'd4;
    tick();
    chk("gl_first_tog", 32'(TOG), 32'b0001);
    REQ = 4'b1001;
    tick();
    chk("gl_tog_e2", 32'(TOG), 32'h0);
    REQ = 4'b0001;
    repeat (3) begin
      tick();
      chk("gl_tog_win", 32'(TOG), 32'h0);
      chk("gl_en_win", 32'(EN), 32'b0001);
    end
    chk("gl_busy_cnt0", 32'(BUSY), 32'h1);
    tick();
    chk("gl_busy_idle", 32'(BUSY), 32'h0);
    tick();
    chk("gl_tog_after", 32'(TOG), 32'h0);
    chk("gl_en_after", 32'(EN), 32'b0001);

    // Asynchronous reset in the middle of a settle window.
    do_reset();
    REQ = 4'b0111; GAP = 4'd2;
    repeat (9) tick();
    chk("ar_pre_en", 32'(EN), 32'b0111);
    chk("ar_pre_tog", 32'(TOG), 32'b0100);
    #2;
    RN = 1'b0;
    model_reset();
    #1;
    chk("ar_en", 32'(EN), 32'h0);
    chk("ar_tog", 32'(TOG), 32'h0);
    chk("ar_stable", 32'(STABLE), 32'h0);
    #1;
    RN = 1'b1;
    @(posedge CLK);
    #1;
    model_edge();
    chk("ar_restart_tog", 32'(TOG), 32'b0001);
    repeat (4) tick();
    chk("ar_second_tog", 32'(TOG), 32'b0010);
    chk("ar_second_en", 32'(EN), 32'b0011);

`ifdef CLKBUF_SEQ_FORCE_EN
    do_reset();
    REQ = 4'b0001; GAP = 4'd5;
    tick();
    chk("fc_pre_en", 32'(EN), 32'b0001);
    REQ = 4'b1010; force_s = 1'b1;
    tick();
    chk("fc_en", 32'(EN), 32'b1010);
    chk("fc_tog", 32'(TOG), 32'b1011);
    chk("fc_busy", 32'(BUSY), 32'h0);
    force_s = 1'b0;
    tick();
    chk("fc_stable", 32'(STABLE), 32'h1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [NB-1:0] prev;
      if ($urandom_range(0, 3) == 0) REQ = NB'($urandom);
      if ($urandom_range(0, 7) == 0) GAP = GAP_W'($urandom_range(0, 3));
`ifdef CLKBUF_SEQ_FORCE_EN
      force_s = ($urandom_range(0, 31) == 0);
`endif
      prev = EN;
      tick();
      chk("rnd_en", 32'(EN), 32'(m_en));
      chk("rnd_tog", 32'(TOG), 32'(m_tog));
      chk("rnd_stable", 32'(STABLE), 32'(m_stable));
      chk("rnd_busy", 32'(BUSY), 32'((m_hold > 0) || (REQ != m_en)));
      if (!force_s) chk("rnd_one_change", 32'($countones(EN ^ prev) <= 1), 32'h1);
    end
    force_s = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
